// File: rtl/dadda_dot8_pkg.sv
// Shared constants and state encoding for the dadda_dot8 dot-product engine.
package dadda_dot8_pkg;

    localparam int DEF_ACC_W   = 20;
    localparam int DEF_MAX_LEN = 16;

    // A len field of zero selects the full 16-pair dot product.
    localparam int LEN_ZERO_VAL = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dadda8.sv
// Combinational 8x8 unsigned Dadda multiplier: partial-product columns are
// reduced through the Dadda height sequence 6,4,3,2 and finished by one adder.
module dadda8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [15:0] col [16];
    logic [15:0] nxt [16];
    int          ht  [16];
    int          nht [16];
    int          idx;
    int          lim;
    int          cn;
    logic        x0, x1, x2;
    logic [15:0] row0, row1;

    function automatic logic bit_at(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [15:0] put(input logic [15:0] v, input int i, input logic bv);
        return v | (16'(bv) << i);
    endfunction

    // Column-wise reduction; each column is a bag of equal-weight bits.
    always_comb begin
        for (int c = 0; c < 16; c++) begin
            col[c] = '0;
            nxt[c] = '0;
            ht[c]  = 0;
            nht[c] = 0;
        end
        idx  = 0;
        lim  = 0;
        cn   = 0;
        x0   = 1'b0;
        x1   = 1'b0;
        x2   = 1'b0;
        row0 = '0;
        row1 = '0;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col[i+j] = put(col[i+j], ht[i+j], a[i] & b[j]);
                ht[i+j]  = ht[i+j] + 1;
            end
        end

        for (int s = 0; s < 4; s++) begin
            lim = (s == 0) ? 6 : (s == 1) ? 4 : (s == 2) ? 3 : 2;
            for (int c = 0; c < 16; c++) begin
                nxt[c] = '0;
                nht[c] = 0;
            end
            // Walk LSB to MSB so carries from column c-1 count toward column c.
            for (int c = 0; c < 16; c++) begin
                idx = 0;
                cn  = (c < 15) ? c + 1 : 15;
                for (int k = 0; k < 6; k++) begin
                    if ((ht[c] - idx + nht[c] > lim) && (ht[c] - idx >= 2)) begin
                        x0 = bit_at(col[c], idx);
                        x1 = bit_at(col[c], idx + 1);
                        x2 = bit_at(col[c], idx + 2);
                        if ((ht[c] - idx + nht[c] == lim + 1) || (ht[c] - idx < 3)) begin
                            nxt[c] = put(nxt[c], nht[c], x0 ^ x1);
                            nht[c] = nht[c] + 1;
                            if (c < 15) begin
                                nxt[cn] = put(nxt[cn], nht[cn], x0 & x1);
                                nht[cn] = nht[cn] + 1;
                            end
                            idx = idx + 2;
                        end else begin
                            nxt[c] = put(nxt[c], nht[c], x0 ^ x1 ^ x2);
                            nht[c] = nht[c] + 1;
                            if (c < 15) begin
                                nxt[cn] = put(nxt[cn], nht[cn], (x0 & x1) | (x0 & x2) | (x1 & x2));
                                nht[cn] = nht[cn] + 1;
                            end
                            idx = idx + 3;
                        end
                    end
                end
                for (int k = 0; k < 16; k++) begin
                    if (k >= idx && k < ht[c]) begin
                        nxt[c] = put(nxt[c], nht[c], bit_at(col[c], k));
                        nht[c] = nht[c] + 1;
                    end
                end
            end
            for (int c = 0; c < 16; c++) begin
                col[c] = nxt[c];
                ht[c]  = nht[c];
            end
        end

        for (int c = 0; c < 16; c++) begin
            row0[c] = bit_at(col[c], 0);
            row1[c] = bit_at(col[c], 1);
        end
    end

    assign p = row0 + row1;

endmodule

// File: rtl/dadda_dot8.sv
// Streaming unsigned dot product of up to MAX_LEN 8-bit pairs. Each accepted
// pair is multiplied, registered, then added into the accumulator one edge later.
module dadda_dot8
    import dadda_dot8_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   len_dec;
    logic [15:0]        mul;
    logic [15:0]        prod;
    logic               prod_vld;
    logic [ACC_W-1:0]   acc;
    logic               accept;
    logic               last_acc;

    dadda8 u_mul (
        .a (in_x),
        .b (in_y),
        .p (mul)
    );

    assign len_dec   = (len == 4'd0) ? CNT_W'(LEN_ZERO_VAL) : CNT_W'(len);
    assign in_ready  = (state == S_ACC) && (cnt < len_q);
    assign accept    = in_valid && in_ready;
    // Products arrive in order, so the one landing while cnt==len_q is the last.
    assign last_acc  = (state == S_ACC) && prod_vld && (cnt == len_q);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_sum   = acc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; start outside IDLE is deliberately ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)     state_nxt = S_ACC;
            S_ACC:   if (last_acc)  state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pair counter, product pipeline register and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            len_q    <= '0;
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else if (state == S_IDLE && start) begin
            cnt      <= '0;
            len_q    <= len_dec;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= accept;
            if (accept) begin
                prod <= mul;
                cnt  <= cnt + 1'b1;
            end
            if (prod_vld) acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: tb/tb_dadda_dot8.sv
// Bench for dadda_dot8: directed scenarios plus randomized dot products,
// checked against a sum-of-products reference computed with plain integers.
module tb_dadda_dot8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_sum;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;
    int px  [16];
    int py  [16];
    int gap [16];

    always #5 clk = ~clk;

    dadda_dot8 #(.ACC_W(20), .MAX_LEN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 16; i++) gap[i] = 0;
    endtask

    // One full dot product: start, feed n pairs (with gap[i] idle cycles
    // before pair i), hold the result for 'hold' cycles, then hand it off.
    task automatic run_op(input int n, input int hold, input bit start_at_hs);
        int want;
        want = 0;
        for (int i = 0; i < n; i++) want += px[i] * py[i];

        start = 1'b1;
        len   = 4'(n);
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("in_ready_after_start", 32'(in_ready), 1);

        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                in_valid = 1'b0;
                start    = 1'($urandom_range(0, 1));
                in_x     = 8'($urandom);
                in_y     = 8'($urandom);
                tick();
                start = 1'b0;
                chk("in_ready_gap", 32'(in_ready), 1);
                chk("out_valid_gap", 32'(out_valid), 0);
            end
            in_valid = 1'b1;
            in_x     = 8'(px[i]);
            in_y     = 8'(py[i]);
            tick();
        end
        in_valid = 1'b0;
        chk("in_ready_after_last", 32'(in_ready), 0);
        chk("out_valid_1_after_last", 32'(out_valid), 0);
        tick();
        chk("out_valid_2_after_last", 32'(out_valid), 1);
        chk("out_sum", 32'(out_sum), 32'(want));

        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            chk("out_valid_hold", 32'(out_valid), 1);
            chk("out_sum_hold", 32'(out_sum), 32'(want));
        end

        out_ready = 1'b1;
        start     = start_at_hs;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("out_valid_after_hs", 32'(out_valid), 0);
        chk("busy_after_hs", 32'(busy), 0);
        chk("in_ready_after_hs", 32'(in_ready), 0);
        if (start_at_hs) begin
            repeat (3) tick();
            chk("in_ready_idle_no_start", 32'(in_ready), 0);
            chk("busy_idle_no_start", 32'(busy), 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_x      = 8'd0;
        in_y      = 8'd0;
        out_ready = 1'b0;
        clear_gaps();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_out_sum", 32'(out_sum), 0);

        // Three back-to-back pairs.
        px[0] = 2;   py[0] = 3;
        px[1] = 4;   py[1] = 5;
        px[2] = 255; py[2] = 255;
        run_op(3, 0, 1'b0);
        chk("len3_sum_const", 32'(out_sum), 65051);

        // Full-length product of maxima, result held under back-pressure.
        for (int i = 0; i < 16; i++) begin px[i] = 255; py[i] = 255; end
        run_op(16, 5, 1'b0);
        chk("len16_sum_const", 32'(out_sum), 1040400);

        // Stall of four idle cycles between the two pairs.
        px[0] = 10; py[0] = 10;
        px[1] = 1;  py[1] = 1;
        gap[1] = 4;
        run_op(2, 0, 1'b0);
        chk("gap_sum_const", 32'(out_sum), 101);
        clear_gaps();

        // Reset in the middle of an operation discards partial results.
        start = 1'b1;
        len   = 4'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_x     = 8'd200;
            in_y     = 8'd150;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_sum", 32'(out_sum), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        px[0] = 7; py[0] = 9;
        run_op(1, 0, 1'b0);
        chk("after_rst_sum_const", 32'(out_sum), 63);

        // start coincident with the output handshake must not restart.
        px[0] = 12; py[0] = 13;
        px[1] = 1;  py[1] = 200;
        run_op(2, 1, 1'b1);

        // Randomized operations with random gaps, stray starts and hold times.
        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) begin
                px[i]  = $urandom_range(0, 255);
                py[i]  = $urandom_range(0, 255);
                gap[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            end
            run_op(n, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
